// File: rtl/lutram_nw_mr_pkg.sv
// Shared types for the multi-write LUTRAM: controller state encoding.
package lutram_nw_mr_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } lutram_state_t;

endpackage

// File: rtl/lutram_nw_mr_bank.sv
// One storage bank: single write port, NUM_READ_PORTS asynchronous read ports, no reset.
module lutram_nw_mr_bank #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 32,
    parameter int NUM_READ_PORTS = 2
) (
    input  logic                                         clk,
    input  logic                                         we,
    input  logic [$clog2(DEPTH)-1:0]                     waddr,
    input  logic [WIDTH-1:0]                             wdata,
    input  logic [NUM_READ_PORTS-1:0][$clog2(DEPTH)-1:0] raddr,
    output logic [NUM_READ_PORTS-1:0][WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_rd
        assign rdata[i] = mem[raddr[i]];
    end

endmodule

// File: rtl/lutram_nw_mr.sv
// Multi-write/multi-read LUTRAM built from per-port banks plus a live-value table.
// Optional same-cycle write-to-read forwarding: define LUTRAM_BYPASS_EN.
//
// state | meaning
// CLEAR | zeroing bank 0 and LVT one address per cycle; writes ignored, reads 0
// READY | normal operation until rst
module lutram_nw_mr
    import lutram_nw_mr_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEPTH           = 32,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int NUM_READ_PORTS  = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_WRITE_PORTS-1:0][$clog2(DEPTH)-1:0] waddr,
    input  logic [NUM_WRITE_PORTS-1:0]                    wen,
    input  logic [NUM_WRITE_PORTS-1:0][WIDTH-1:0]         wdata,
    input  logic [NUM_READ_PORTS-1:0][$clog2(DEPTH)-1:0]  raddr,
    output logic [NUM_READ_PORTS-1:0][WIDTH-1:0]          rdata,
    output logic                                          ready
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVT_W = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

    lutram_state_t state;
    logic [AW-1:0] clr_cnt;
    logic          clearing;
    logic          live;

    assign clearing = (state == CLEAR);
    assign live     = (state == READY) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    // Counter parks at the last address; it never wraps.
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                    ready <= 1'b1;
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    logic [NUM_WRITE_PORTS-1:0]                              bank_we;
    logic [NUM_WRITE_PORTS-1:0][AW-1:0]                      bank_waddr;
    logic [NUM_WRITE_PORTS-1:0][WIDTH-1:0]                   bank_wdata;
    logic [NUM_WRITE_PORTS-1:0][NUM_READ_PORTS-1:0][WIDTH-1:0] bank_rdata;

    // Bank 0 doubles as the clear target, so its write port is muxed with the counter.
    always_comb begin
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            bank_we[p]    = wen[p] && live;
            bank_waddr[p] = waddr[p];
            bank_wdata[p] = wdata[p];
        end
        if (clearing) begin
            bank_we[0]    = 1'b1;
            bank_waddr[0] = clr_cnt;
            bank_wdata[0] = '0;
        end
    end

    for (genvar p = 0; p < NUM_WRITE_PORTS; p++) begin : g_bank
        lutram_nw_mr_bank #(
            .WIDTH          (WIDTH),
            .DEPTH          (DEPTH),
            .NUM_READ_PORTS (NUM_READ_PORTS)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[p]),
            .waddr (bank_waddr[p]),
            .wdata (bank_wdata[p]),
            .raddr (raddr),
            .rdata (bank_rdata[p])
        );
    end

    logic [LVT_W-1:0] lvt [DEPTH];

    // Ascending port order makes the highest-indexed writer the last assignment.
    always_ff @(posedge clk) begin
        if (clearing) begin
            lvt[clr_cnt] <= '0;
        end else if (live) begin
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                if (wen[p]) begin
                    lvt[waddr[p]] <= LVT_W'(p);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            rdata[i] = '0;
            if (live) begin
                rdata[i] = bank_rdata[lvt[raddr[i]]][i];
`ifdef LUTRAM_BYPASS_EN
                for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                    if (wen[p] && (waddr[p] == raddr[i])) begin
                        rdata[i] = wdata[p];
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_lutram_nw_mr.sv
// Directed bench for lutram_nw_mr (default 32x32, 2 write, 2 read) plus a golden-model soak.
module tb_lutram_nw_mr;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][4:0]  waddr;
    logic [1:0]       wen;
    logic [1:0][31:0] wdata;
    logic [1:0][4:0]  raddr;
    logic [1:0][31:0] rdata;
    logic             ready;

    int checks   = 0;
    int failures = 0;
    int n;
    logic [31:0] model [32];
    logic [31:0] exp_rd;
    logic [31:0] bypass_exp;

    lutram_nw_mr dut (
        .clk   (clk),
        .rst   (rst),
        .waddr (waddr),
        .wen   (wen),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata),
        .ready (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        wen   = '0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
        repeat (3) tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata0", rdata[0], 32'd0);
        check("rst_rdata1", rdata[1], 32'd0);

        // ready must rise exactly 32 cycles after rst falls
        rst = 1'b0;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        check("clear_latency", n, 32);

        for (int a = 0; a < 32; a++) begin
            raddr[0] = 5'(a);
            raddr[1] = 5'(31 - a);
            #1;
            check("post_clear_rd0", rdata[0], 32'd0);
            check("post_clear_rd1", rdata[1], 32'd0);
        end

        // port0 then port1 to the same address on consecutive cycles
        wen = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'hAAAA0000;
        raddr[0] = 5'd5;
        tick();
        check("p0_write_5", rdata[0], 32'hAAAA0000);
        wen = 2'b10; waddr[1] = 5'd5; wdata[1] = 32'hBBBB0000;
        tick();
        wen = 2'b00;
        #1;
        check("p1_overwrite_5", rdata[0], 32'hBBBB0000);

        // same-cycle collision: highest port wins
        wen = 2'b11; waddr[0] = 5'd7; wdata[0] = 32'h11; waddr[1] = 5'd7; wdata[1] = 32'h22;
        tick();
        wen = 2'b00; raddr[1] = 5'd7;
        #1;
        check("collision_7", rdata[1], 32'h22);

        // port1 then port0 to the same address: LVT must move back to bank 0
        wen = 2'b10; waddr[1] = 5'd3; wdata[1] = 32'h44;
        tick();
        wen = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h55;
        tick();
        wen = 2'b00; raddr[0] = 5'd3; raddr[1] = 5'd5;
        #1;
        check("lvt_back_to_p0", rdata[0], 32'h55);
        check("other_addr_kept", rdata[1], 32'hBBBB0000);

        // same-cycle write and read of address 9
`ifdef LUTRAM_BYPASS_EN
        bypass_exp = 32'h33;
`else
        bypass_exp = 32'h0;
`endif
        wen = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h33; raddr[0] = 5'd9;
        #1;
        check("same_cycle_rw_9", rdata[0], bypass_exp);
        tick();
        wen = 2'b00;
        #1;
        check("after_write_9", rdata[0], 32'h33);

        // reset in READY, reset again at clear count 10, writes attempted during clear
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wen = 2'b11; waddr[0] = 5'd20; wdata[0] = 32'hDEAD0000; waddr[1] = 5'd21; wdata[1] = 32'hBEEF0000;
        raddr[0] = 5'd5; raddr[1] = 5'd7;
        #1;
        check("clear_forced_rd0", rdata[0], 32'd0);
        check("clear_forced_rd1", rdata[1], 32'd0);
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        wen = 2'b00;
        check("reclear_latency", n, 32);
        raddr[0] = 5'd20; raddr[1] = 5'd21;
        #1;
        check("ignored_write_p0", rdata[0], 32'd0);
        check("ignored_write_p1", rdata[1], 32'd0);
        raddr[0] = 5'd5; raddr[1] = 5'd9;
        #1;
        check("reclear_addr5", rdata[0], 32'd0);
        check("reclear_addr9", rdata[1], 32'd0);

        // soak against a highest-port-wins model
        for (int a = 0; a < 32; a++) model[a] = 32'd0;
        for (int c = 0; c < 2000; c++) begin
            wen      = 2'($urandom_range(0, 3));
            waddr[0] = 5'($urandom_range(0, 31));
            waddr[1] = 5'($urandom_range(0, 31));
            wdata[0] = $urandom;
            wdata[1] = $urandom;
            raddr[0] = 5'($urandom_range(0, 31));
            raddr[1] = 5'($urandom_range(0, 31));
            #1;
            for (int i = 0; i < 2; i++) begin
                exp_rd = model[raddr[i]];
`ifdef LUTRAM_BYPASS_EN
                for (int p = 0; p < 2; p++) begin
                    if (wen[p] && waddr[p] == raddr[i]) exp_rd = wdata[p];
                end
`endif
                check("soak_read", rdata[i], exp_rd);
            end
            for (int p = 0; p < 2; p++) begin
                if (wen[p]) model[waddr[p]] = wdata[p];
            end
            tick();
        end
        wen = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
